// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch stage: default address
//   window and reset PC, the NOP encoding, the fetch FSM state type and the
//   packed IF/ID pipeline payload.
package fetch_pkg;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
   localparam logic [31:0] DEF_TEXT_BASE = 32'h0040_0000;
   localparam logic [31:0] DEF_TEXT_LAST = 32'h0040_4000;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } ifid_t;

   // A bubble carries no instruction and zeroes every field so that
   // downstream stages never see stale PCs attached to an invalid slot.
   localparam ifid_t IFID_BUBBLE = '{
      valid:    1'b0,
      instr:    NOP_INSTR,
      pc:       32'h0000_0000,
      pc_plus4: 32'h0000_0000
   };

   // True when a fetch address lies outside [base, last] or is not word
   // aligned. All comparisons are unsigned.
   function automatic logic pc_is_bad(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] last);
      return (pc[1:0] != 2'b00) || (pc < base) || (pc > last);
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg
//   IF/ID pipeline register. Bubble has priority over load; with neither
//   asserted the register holds its contents.
//   Ports:
//     clk, rst_n        clock and asynchronous active-low reset
//     load_i            capture {valid=1, instr_i, pc_i, pc_plus4_i}
//     bubble_i          capture an empty slot (all fields zero)
//     instr_i, pc_i, pc_plus4_i   payload to capture on load
//     valid_o, instr_o, pc_o, pc_plus4_o   registered payload
module ifid_reg
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        bubble_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus4_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o
);

   ifid_t ifid_q;
   ifid_t ifid_d;

   always_comb begin
      ifid_d = ifid_q;
      if (bubble_i) begin
         ifid_d = IFID_BUBBLE;
      end else if (load_i) begin
         ifid_d.valid    = 1'b1;
         ifid_d.instr    = instr_i;
         ifid_d.pc       = pc_i;
         ifid_d.pc_plus4 = pc_plus4_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_q <= IFID_BUBBLE;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign valid_o    = ifid_q.valid;
   assign instr_o    = ifid_q.instr;
   assign pc_o       = ifid_q.pc;
   assign pc_plus4_o = ifid_q.pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage: owns the PC, addresses the combinational
//   instruction memory, and registers the returned word into IF/ID.
//   A fetch from an address outside the text window or misaligned moves the
//   stage into a sticky FAULT state that only reset leaves.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     stall_i                    hold PC and IF/ID
//     redirect_i, redirect_pc_i  load PC from a resolved branch/jump target
//     imem_addr_o                fetch byte address (always the PC)
//     imem_instr_i               word returned by memory in the same cycle
//     ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus4_o  IF/ID payload
//     fault_o, fault_pc_o        sticky fault flag and offending PC
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] TEXT_BASE = DEF_TEXT_BASE,
   parameter logic [31:0] TEXT_LAST = DEF_TEXT_LAST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   output logic        ifid_valid_o,
   output logic [31:0] ifid_instr_o,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_pc_plus4_o,
   output logic        fault_o,
   output logic [31:0] fault_pc_o
);

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   logic [31:0]  fault_pc_q;
   logic [31:0]  fault_pc_d;

   logic [31:0]  pc_plus4;
   logic         pc_bad;
   logic         ifid_load;
   logic         ifid_bubble;

   // Wraps modulo 2^32; a wrapped 0 is then caught by the range check.
   assign pc_plus4 = pc_q + 32'd4;
   assign pc_bad   = pc_is_bad(pc_q, TEXT_BASE, TEXT_LAST);

   // Next-state / next-PC. Priority in RUN: redirect, stall, bad PC, fetch.
   // Redirect is taken ahead of the bad-PC check so that a wrong-path PC
   // that is squashed by a branch never raises a fault. Redirect targets are
   // not checked when loaded; they are checked on the edge that would fetch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fault_pc_d  = fault_pc_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (redirect_i) begin
               pc_d        = redirect_pc_i;
               ifid_bubble = 1'b1;
            end else if (stall_i) begin
               // hold PC and IF/ID
            end else if (pc_bad) begin
               state_d     = ST_FAULT;
               fault_pc_d  = pc_q;
               ifid_bubble = 1'b1;
            end else begin
               pc_d      = pc_plus4;
               ifid_load = 1'b1;
            end
         end
         default: begin
            // FAULT: all control inputs ignored, IF/ID pinned to bubble.
            ifid_bubble = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         fault_pc_q <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   ifid_reg u_ifid_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ifid_load),
      .bubble_i   (ifid_bubble),
      .instr_i    (imem_instr_i),
      .pc_i       (pc_q),
      .pc_plus4_i (pc_plus4),
      .valid_o    (ifid_valid_o),
      .instr_o    (ifid_instr_o),
      .pc_o       (ifid_pc_o),
      .pc_plus4_o (ifid_pc_plus4_o)
   );

   assign imem_addr_o = pc_q;
   assign fault_o     = (state_q == ST_FAULT);
   assign fault_pc_o  = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed steps followed by a randomized phase, each edge checked against
//   a behavioural model of the fetch rules kept in this bench.
module tb_fetch_stage;

   localparam logic [31:0] R_PC   = 32'h0040_0000;
   localparam logic [31:0] T_BASE = 32'h0040_0000;
   localparam logic [31:0] T_LAST = 32'h0040_4000;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic        ifid_valid_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_pc_plus4_o;
   logic        fault_o;
   logic [31:0] fault_pc_o;

   int total;
   int bad;
   int ncyc;

   // behavioural model state
   logic [31:0] m_pc;
   logic        m_fault;
   logic [31:0] m_fault_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;

   fetch_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_i         (stall_i),
      .redirect_i      (redirect_i),
      .redirect_pc_i   (redirect_pc_i),
      .imem_addr_o     (imem_addr_o),
      .imem_instr_i    (imem_instr_i),
      .ifid_valid_o    (ifid_valid_o),
      .ifid_instr_o    (ifid_instr_o),
      .ifid_pc_o       (ifid_pc_o),
      .ifid_pc_plus4_o (ifid_pc_plus4_o),
      .fault_o         (fault_o),
      .fault_pc_o      (fault_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synthetic memory contents: a scrambled function of the address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   assign imem_instr_i = mem(imem_addr_o);

   function automatic logic addr_illegal(input logic [31:0] a);
      return ((a % 32'd4) != 32'd0) || (a < T_BASE) || (a > T_LAST);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".addr"},     imem_addr_o,             m_pc);
      chk({tag, ".valid"},    {31'd0, ifid_valid_o},   {31'd0, m_valid});
      chk({tag, ".instr"},    ifid_instr_o,            m_valid ? m_instr : 32'd0);
      chk({tag, ".ipc"},      ifid_pc_o,               m_valid ? m_ipc : 32'd0);
      chk({tag, ".ipc4"},     ifid_pc_plus4_o,         m_valid ? m_ipc + 32'd4 : 32'd0);
      chk({tag, ".fault"},    {31'd0, fault_o},        {31'd0, m_fault});
      chk({tag, ".fault_pc"}, fault_pc_o,              m_fault_pc);
   endtask

   task automatic model_reset();
      m_pc       = R_PC;
      m_fault    = 1'b0;
      m_fault_pc = 32'd0;
      m_valid    = 1'b0;
      m_instr    = 32'd0;
      m_ipc      = 32'd0;
   endtask

   // One clock edge: drive inputs, advance the model, check after the edge.
   task automatic cyc(input logic s, input logic r, input logic [31:0] t);
      stall_i       = s;
      redirect_i    = r;
      redirect_pc_i = t;
      if (!m_fault) begin
         if (r) begin
            m_pc    = t;
            m_valid = 1'b0;
         end else if (s) begin
            // nothing moves
         end else if (addr_illegal(m_pc)) begin
            m_fault    = 1'b1;
            m_fault_pc = m_pc;
            m_valid    = 1'b0;
         end else begin
            m_valid = 1'b1;
            m_instr = mem(m_pc);
            m_ipc   = m_pc;
            m_pc    = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      ncyc++;
      $display("cyc %0d stall=%0b redir=%0b tgt=%h -> addr=%h valid=%0b ifid_pc=%h fault=%0b fault_pc=%h",
               ncyc, s, r, t, imem_addr_o, ifid_valid_o, ifid_pc_o, fault_o, fault_pc_o);
      chk_all("cyc");
   endtask

   // Asserts reset between clock edges, checks the immediate effect, then
   // releases it just after the following rising edge.
   task automatic async_reset();
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'd0;
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      $display("async reset -> addr=%h valid=%0b fault=%0b", imem_addr_o, ifid_valid_o, fault_o);
      chk_all("arst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      case ($urandom_range(0, 9))
         0:       t = 32'h0000_0100;
         1:       t = T_LAST - 32'd4 * 32'($urandom_range(0, 3));
         2:       t = T_BASE + 32'($urandom_range(1, 3));
         3:       t = 32'hFFFF_FFFC;
         default: t = T_BASE + 32'd4 * 32'($urandom_range(0, 255));
      endcase
      return t;
   endfunction

   initial begin
      total         = 0;
      bad           = 0;
      ncyc          = 0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'd0;
      rst_n         = 1'b1;
      model_reset();

      // reset takes effect before any clock edge
      #1 rst_n = 1'b0;
      #1;
      chk_all("reset");
      chk("reset.addr_const", imem_addr_o, 32'h0040_0000);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // free running
      cyc(1'b0, 1'b0, 32'd0);
      chk("run.ifid_pc0", ifid_pc_o, 32'h0040_0000);
      cyc(1'b0, 1'b0, 32'd0);
      chk("run.ifid_pc1", ifid_pc_o, 32'h0040_0004);
      chk("run.addr2",    imem_addr_o, 32'h0040_0008);

      // stall two cycles at 0x00400008, then resume
      cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 32'd0);
      chk("stall.addr", imem_addr_o, 32'h0040_0008);
      cyc(1'b0, 1'b0, 32'd0);
      chk("resume.addr", imem_addr_o, 32'h0040_000C);

      // redirect wins over stall
      cyc(1'b1, 1'b1, 32'h0040_0100);
      chk("redir.addr", imem_addr_o, 32'h0040_0100);
      cyc(1'b0, 1'b0, 32'd0);
      chk("redir.ifid_pc", ifid_pc_o, 32'h0040_0100);

      // bad PC while stalled does not fault; redirect away from it
      cyc(1'b0, 1'b1, 32'h0000_0100);
      cyc(1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b0, 32'd0);
      chk("stallbad.fault", {31'd0, fault_o}, 32'd0);
      cyc(1'b0, 1'b1, 32'h0040_0000);
      cyc(1'b0, 1'b0, 32'd0);

      // misaligned target faults on the next committing edge
      cyc(1'b0, 1'b1, 32'h0040_0102);
      cyc(1'b0, 1'b0, 32'd0);
      chk("mis.fault_pc", fault_pc_o, 32'h0040_0102);
      cyc(1'b0, 1'b1, 32'h0040_0000);
      cyc(1'b1, 1'b0, 32'd0);
      chk("mis.sticky_addr", imem_addr_o, 32'h0040_0102);

      // async reset out of FAULT
      async_reset();

      // upper boundary: TEXT_LAST valid, TEXT_LAST+4 faults
      cyc(1'b0, 1'b1, 32'h0040_3FF8);
      cyc(1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b0, 32'd0);
      chk("top.ifid_pc", ifid_pc_o, 32'h0040_4000);
      chk("top.valid",   {31'd0, ifid_valid_o}, 32'd1);
      cyc(1'b0, 1'b0, 32'd0);
      chk("top.fault_pc", fault_pc_o, 32'h0040_4004);
      async_reset();

      // PC at TEXT_LAST+4 rescued by a same-cycle redirect
      cyc(1'b0, 1'b1, 32'h0040_4000);
      cyc(1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b1, 32'h0040_0000);
      chk("rescue.fault", {31'd0, fault_o}, 32'd0);
      cyc(1'b0, 1'b0, 32'd0);
      chk("rescue.ifid_pc", ifid_pc_o, 32'h0040_0000);

      // just below the window
      cyc(1'b0, 1'b1, 32'h003F_FFFC);
      cyc(1'b0, 1'b0, 32'd0);
      chk("low.fault_pc", fault_pc_o, 32'h003F_FFFC);
      async_reset();

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         if (m_fault && ($urandom_range(0, 3) == 0)) begin
            async_reset();
         end else begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), pick_target());
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
